// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, trap/branch redirects and
// a one-entry redirect buffer for stalls. Optional return-address stack under `PC_RAS_EN.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            valid_o,
  output logic            pending_o,
  output logic            misalign_o,
  output logic            ras_empty_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_trap_q, pend_trap_d;
  logic            misalign_q, misalign_d;

  logic            ras_pop;
  logic [XLEN-1:0] ras_top_pc;

  assign pc_o       = pc_q;
  assign pc_plus_o  = pc_q + XLEN'(INC);
  assign misalign_o = misalign_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    if (!rst_ni) state_q <= S_BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (!enable_i && (trap_i || redirect_i)) state_d = S_HOLD;
      S_HOLD:  if (enable_i) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    valid_o   = (state_q != S_BOOT);
    pending_o = (state_q == S_HOLD);
  end

  // ---------------------------------------------------------------------------
  // Next-PC selection and redirect buffering
  // ---------------------------------------------------------------------------
  logic            load_en;
  logic [XLEN-1:0] load_pc;

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise a path
    // that skips the assignment would infer a latch.
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_trap_d = pend_trap_q;
    misalign_d  = 1'b0;
    load_en     = 1'b0;
    load_pc     = '0;

    if (state_q != S_BOOT) begin
      if (enable_i) begin
        pend_pc_d   = '0;
        pend_trap_d = 1'b0;
        if (trap_i) begin
          load_en = 1'b1;
          load_pc = trap_vec_i;
        end else if (redirect_i) begin
          load_en = 1'b1;
          load_pc = redirect_pc_i;
        end else if (state_q == S_HOLD) begin
          load_en = 1'b1;
          load_pc = pend_pc_q;
        end else if (ras_pop) begin
          load_en = 1'b1;
          load_pc = ras_top_pc;
        end else begin
          pc_d = pc_plus_o;
        end
      end else begin
        // A buffered trap is never displaced by a later redirect.
        if (trap_i) begin
          pend_pc_d   = trap_vec_i;
          pend_trap_d = 1'b1;
        end else if (redirect_i && !((state_q == S_HOLD) && pend_trap_q)) begin
          pend_pc_d   = redirect_pc_i;
          pend_trap_d = 1'b0;
        end
      end

      if (load_en) begin
        pc_d       = {load_pc[XLEN-1:2], 2'b00};
        misalign_d = |load_pc[1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q        <= RESET_VEC;
      pend_pc_q   <= '0;
      pend_trap_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_trap_q <= pend_trap_d;
      misalign_q  <= misalign_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------------
`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top_q, ras_top_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [PTR_W-1:0] top_inc, top_dec, ras_waddr;
  logic             ras_sample, ras_push, ras_flush, ras_we;

  // The stack only acts on a plain sequential fetch; any redirect takes over.
  assign ras_sample = (state_q == S_RUN) && enable_i && !trap_i && !redirect_i;
  assign ras_pop    = ras_sample && ret_i && (ras_cnt_q != '0);
  assign ras_push   = ras_sample && call_i;
  assign ras_flush  = (state_q != S_BOOT) && trap_i;
  assign ras_top_pc = ras_mem_q[ras_top_q];
  assign ras_empty_o = (ras_cnt_q == '0);

  assign top_inc = (ras_top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_top_q + 1'b1;
  assign top_dec = (ras_top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_top_q - 1'b1;

  always_comb begin
    ras_top_d = ras_top_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ras_top_q;
    if (ras_flush) begin
      ras_top_d = '0;
      ras_cnt_d = '0;
    end else if (ras_pop && ras_push) begin
      ras_we = 1'b1;
    end else if (ras_pop) begin
      ras_top_d = top_dec;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end else if (ras_push) begin
      // When full the pointer simply wraps onto the oldest entry.
      ras_top_d = top_inc;
      ras_waddr = top_inc;
      ras_we    = 1'b1;
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ras_top_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_top_q <= ras_top_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; the occupancy count alone decides
  // which entries are meaningful, so the array can map onto plain flops/RAM.
  always_ff @(posedge clk_i) begin
    if (ras_we) ras_mem_q[ras_waddr] <= pc_plus_o;
  end
`else
  logic ras_unused;

  assign ras_pop     = 1'b0;
  assign ras_top_pc  = '0;
  assign ras_empty_o = 1'b1;
  assign ras_unused  = call_i ^ ret_i ^ (RAS_DEPTH > 0);
`endif

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch program-counter generator; successor to the single-register PC.
- Holds the fetch PC.
- Advances sequentially by a configurable increment.
- Resolves trap and branch redirects with fixed priority.
- Buffers a redirect that arrives while fetch is stalled by an I-cache miss, so no redirect is lost.
- Sits between the branch/trap logic and the I-cache fetch port.

Parameters:
XLEN, 32, PC width in bits
RESET_VEC, 32'h0000_0000, PC value loaded during reset
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  synchronous active-low reset
enable_i  input  1  1 = fetch may advance; 0 = stall (cache miss), PC held
redirect_i  input  1  branch/jump taken this cycle
redirect_pc_i  input  XLEN  branch/jump target
trap_i  input  1  trap/exception taken this cycle
trap_vec_i  input  XLEN  trap handler address
call_i  input  1  current fetch is a call (RAS push)
ret_i  input  1  current fetch is a return (RAS pop)
pc_o  output  XLEN  current fetch PC
pc_plus_o  output  XLEN  pc_o + INC, combinational, modulo 2^XLEN
valid_o  output  1  pc_o is a valid fetch address
pending_o  output  1  a redirect is buffered, awaiting enable_i
misalign_o  output  1  one-cycle flag: last loaded target had nonzero bits [1:0]
ras_empty_o  output  1  RAS holds no entries

Behaviour:
- Clock is clk_i; reset is synchronous, active-low, on rst_ni. Sampled only at the rising clk_i edge.
- Reset values: pc_o=RESET_VEC, valid_o=0, pending_o=0, misalign_o=0, ras_empty_o=1. Pending register and RAS are cleared.
- Reset has priority over every other input, including mid-stall with a pending redirect; the pending redirect is discarded.
- States and transitions:
  - BOOT: entered on reset. First edge with rst_ni=1 goes to RUN and sets valid_o=1; pc_o stays RESET_VEC.
  - RUN: normal fetch. Goes to HOLD when enable_i=0 and (trap_i or redirect_i).
  - HOLD: pending_o=1. Returns to RUN on the first edge with enable_i=1, applying the buffered target.
- Next-PC priority when enable_i=1:
  1. trap_i → trap_vec_i
  2. redirect_i → redirect_pc_i
  3. pending → pending target
  4. RAS pop (PC_RAS_EN only)
  5. otherwise pc_o+INC
- Latency: a target presented with enable_i=1 appears on pc_o one cycle later.
- When enable_i=1, the pending register is cleared on the same edge.
- When enable_i=0, pc_o holds. Capture rules:
  - trap_i: captures trap_vec_i and overwrites any pending entry.
  - redirect_i: captures redirect_pc_i only if no trap is pending.
  - trap_i and redirect_i in the same cycle: trap wins.
- Redirect and enable_i=1 in the same cycle as a pending entry: the live input wins; the pending entry is dropped.
- Alignment: every loaded non-sequential target has bits [1:0] forced to 0. misalign_o=1 for exactly the cycle after that load if the original bits [1:0] were nonzero.
- Wrap-around: pc_o+INC is computed modulo 2^XLEN. Example: 32'hFFFF_FFFC → 32'h0000_0000, with no flag.
- valid_o stays 1 during stalls. It drops only in BOOT/reset.

Optional Feature:
Macro PC_RAS_EN.
- Defined: RAS of RAS_DEPTH XLEN-bit entries. Sampled only when enable_i=1 and no trap/redirect/pending applies.
  - call_i pushes pc_plus_o.
  - ret_i pops the top entry as the next PC.
  - call_i and ret_i together: pop first, then push (top is replaced).
  - Push when full: circular overwrite of the oldest entry.
  - ret_i when empty: sequential pc_o+INC, ras_empty_o stays 1.
  - Trap flushes the RAS.
- Undefined: call_i and ret_i are ignored, ras_empty_o is tied to 1, and no RAS storage is synthesised.

Test Plan:
- Reset then release, enable_i=1 → pc_o 0x0 (valid_o 0), then 0x0 (valid_o 1), 0x4, 0x8.
- redirect_i=1 with redirect_pc_i=0x100 and enable_i=1 → next pc_o=0x100, then 0x104.
- enable_i=0, redirect 0x200 pulse, 3 stall cycles, then enable_i=1 → pc_o holds and pending_o=1 throughout the stall; next pc_o=0x200, pending_o=0.
- Stalled: trap 0x80 in one cycle, then redirect 0x300 in the next, then enable_i=1 → pc_o=0x80 (trap kept).
- redirect_pc_i=0x102 → pc_o=0x100, misalign_o=1 for one cycle. Separately, pc_o=0xFFFF_FFFC → next 0x0.
- PC_RAS_EN: call at 0x10, then ret_i → pc_o=0x14. ret_i on empty → pc_o+4, ras_empty_o=1. Five calls with RAS_DEPTH=4 → four pops return the newest four.
